decode3_8_scan: RTL
===================

DECODE3_8_SCAN -- requirements
Module: decode3_8_scan

Interface
REQ-001 SHALL have parameter DIV, default 25000000: scan step period in clk cycles (legal range 2..2^26).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port en, input, 1 bit: output enable; 0 blanks all outputs and freezes state.
REQ-005 SHALL have port load, input, 1 bit: strobe to capture code.
REQ-006 SHALL have port code, input, 3 bits: binary index to display.
REQ-007 SHALL have port mode, input, 1 bit: 0 holds the value, 1 auto-scans upward.
REQ-008 SHALL have port clr, input, 1 bit: synchronous return to IDLE.
REQ-009 SHALL have port y, output, 8 bits: one-hot decode of cur, where y[cur] = 1.
REQ-010 SHALL have port cur, output, 3 bits: current index register.
REQ-011 SHALL have port stat, output, 1 bit: 1 while a valid index is displayed.
REQ-012 SHALL have port hex, output, 7 bits: active-low seven-segment digit of cur.

Function
REQ-013 SHALL implement states IDLE, HOLD and SCAN, plus registers cur[2:0] and div_cnt.
REQ-014 SHALL, when en=0, leave all state and div_cnt unchanged and ignore load, clr and mode.
REQ-015 SHALL give transitions the following priority at each edge with en=1: clr, then load, then mode, then tick.
- clr=1: go to IDLE, cur=0, div_cnt=0.
- load=1 with mode=0: go to HOLD, cur=code, div_cnt=0.
- load=1 with mode=1: go to SCAN, cur=code, div_cnt=0.
- In HOLD with mode=1 and no load: go to SCAN, keep cur, div_cnt=0.
- In SCAN with mode=0 and no load: go to HOLD, keep cur.
- In IDLE with no load: stay in IDLE, regardless of mode.
REQ-016 SHALL, in SCAN with en=1 and no clr/load/mode change, increment div_cnt each cycle.
- When div_cnt=DIV-1: div_cnt=0 and cur=cur+1 modulo 8 (7 wraps to 0).
- The first advance therefore occurs DIV cycles after entering SCAN.
REQ-017 SHALL give load priority over a coincident tick: cur=code, with no increment on that edge.
REQ-018 SHALL derive y, stat and hex combinationally from the registered state, cur and the live en.
- A load sampled at edge k is visible immediately after edge k: 1-cycle latency, no pipeline.
REQ-019 SHALL drive outputs, when en=1 and state is HOLD or SCAN, as: stat=1, y=1<<cur, hex per REQ-020.
REQ-020 SHALL use this hex table (segment order g..a, active-low):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
REQ-021 SHALL drive outputs, when en=0 or state is IDLE, as: stat=0, y=00000000, hex=1111111.
REQ-022 SHALL leave cur visible on the cur port at all times, including while blanked.
REQ-023 SHALL produce no X values on any output after reset.

Reset
REQ-024 SHALL, on rst=1 and asynchronously with no clock edge required, set state=IDLE, cur=0 and div_cnt=0.
- Resulting outputs: y=0, stat=0, hex=1111111.
REQ-025 SHALL, on rst asserted mid-SCAN, abort the scan immediately and hold all registers in reset until rst falls.
REQ-026 SHALL, on the first edge after rst deasserts, honour load/clr normally; no extra wait cycle.

Verification (DIV=4)
REQ-027 SHALL cover: reset, then en=1 with no load for 10 cycles -> stat=0, y=00, hex=7F throughout.
REQ-028 SHALL cover: en=1, mode=0, load=1 with code=5 for 1 cycle -> after that edge, cur=5, y=0x20, stat=1, hex=0010010; held unchanged for 20 cycles.
REQ-029 SHALL cover: load code=6 with mode=1 -> cur sequence 6,7,0,1 with each value lasting exactly 4 cycles, and y=0x40,0x80,0x01,0x02.
REQ-030 SHALL cover: in SCAN, load code=2 on the cycle where div_cnt=3 -> cur=2 (not 3 and not 7+1); the next advance to 3 comes 4 cycles later.
REQ-031 SHALL cover: in SCAN, drop en to 0 for 6 cycles -> outputs blanked, cur frozen; on restoring en, outputs resume the same cur and div_cnt continues from its frozen value.
REQ-032 SHALL cover: in SCAN at cur=3, assert rst between clock edges -> stat=0 and cur=0 before the next edge; after release, clr=1 gives IDLE and load with code=1 gives y=0x02.

Source files
------------

// File: rtl/decode3_8_scan_if.sv
// ----------------------------------------------------------------------------
// decode3_8_scan_if
// Bundles the control inputs and display outputs of decode3_8_scan.
//   en    : output enable; 0 blanks the display and freezes the scanner
//   load  : strobe that captures code into the index register
//   code  : 3-bit index to display
//   mode  : 0 holds the current index, 1 auto-scans upward
//   clr   : synchronous return to IDLE
//   y     : one-hot decode of cur
//   cur   : current index register (always visible)
//   stat  : 1 while a valid index is displayed
//   hex   : active-low seven-segment digit of cur (segment order g..a)
// The master modport drives the controls; the slave modport is the decoder.
// ----------------------------------------------------------------------------
interface decode3_8_scan_if;
    logic       en;
    logic       load;
    logic [2:0] code;
    logic       mode;
    logic       clr;
    logic [7:0] y;
    logic [2:0] cur;
    logic       stat;
    logic [6:0] hex;

    modport master (
        output en, load, code, mode, clr,
        input  y, cur, stat, hex
    );

    modport slave (
        input  en, load, code, mode, clr,
        output y, cur, stat, hex
    );
endinterface

// File: rtl/decode3_8_scan.sv
// ----------------------------------------------------------------------------
// decode3_8_scan
// 3-to-8 decoder with a held or auto-scanning index and a seven-segment view.
// Parameters:
//   DIV : scan step period in clk cycles (2 .. 2^26)
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-high reset (IDLE, cur=0, divider cleared)
//   bus : decode3_8_scan_if.slave carrying en/load/code/mode/clr in and
//         y/cur/stat/hex out
// The display outputs are combinational from the registered state, the
// registered index and the live en, so a load is visible right after its edge.
// ----------------------------------------------------------------------------
module decode3_8_scan #(
    parameter int DIV = 25000000
) (
    input  logic                 clk,
    input  logic                 rst,
    decode3_8_scan_if.slave      bus
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t        r_state;
    logic [2:0]    r_cur;
    logic [CW-1:0] r_divCnt;

    logic          w_active;
    logic [6:0]    w_hex;

    // Control FSM and scan divider. Nothing moves while en is low. Among the
    // enabled actions clr wins, then load, then a mode change, and only an
    // undisturbed SCAN cycle counts toward the next step, so a load landing
    // on the terminal count replaces the index instead of stepping it.
    // Leaving SCAN for HOLD clears the divider so a later resume starts a
    // fresh full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cur    <= 3'd0;
            r_divCnt <= '0;
        end else if (bus.en) begin
            if (bus.clr) begin
                r_state  <= IDLE;
                r_cur    <= 3'd0;
                r_divCnt <= '0;
            end else if (bus.load) begin
                r_state  <= bus.mode ? SCAN : HOLD;
                r_cur    <= bus.code;
                r_divCnt <= '0;
            end else begin
                case (r_state)
                    HOLD: begin
                        if (bus.mode) begin
                            r_state  <= SCAN;
                            r_divCnt <= '0;
                        end
                    end
                    SCAN: begin
                        if (!bus.mode) begin
                            r_state  <= HOLD;
                            r_divCnt <= '0;
                        end else if (r_divCnt == LAST) begin
                            r_divCnt <= '0;
                            r_cur    <= r_cur + 3'd1;
                        end else begin
                            r_divCnt <= r_divCnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Seven-segment lookup for the current index, active-low, g..a.
    always_comb begin
        w_hex = 7'b1111111;
        case (r_cur)
            3'd0: w_hex = 7'b1000000;
            3'd1: w_hex = 7'b1111001;
            3'd2: w_hex = 7'b0100100;
            3'd3: w_hex = 7'b0110000;
            3'd4: w_hex = 7'b0011001;
            3'd5: w_hex = 7'b0010010;
            3'd6: w_hex = 7'b0000010;
            3'd7: w_hex = 7'b1111000;
            default: w_hex = 7'b1111111;
        endcase
    end

    // The display is live only when enabled and a value has been loaded;
    // otherwise everything is blanked, but cur stays visible regardless.
    assign w_active = bus.en && (r_state != IDLE);
    assign bus.stat = w_active;
    assign bus.y    = w_active ? (8'b0000_0001 << r_cur) : 8'b0000_0000;
    assign bus.hex  = w_active ? w_hex : 7'b1111111;
    assign bus.cur  = r_cur;

endmodule
